// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: register-address, funct3 and ALU-op widths,
// the x0 address, and the decoded control bundle carried from ID into EX.
package id_ex_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned ALU_OP_W   = 4;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = REG_ADDR_W'(0);

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoded-instruction bus into the ID/EX register and the registered EX-side copy out of it.
interface id_ex_stage_if #(parameter int unsigned DATA_W = 32);
    import id_ex_stage_pkg::*;

    logic [REG_ADDR_W-1:0] i_IF_ID_rs1, i_IF_ID_rs2, i_IF_ID_rd;
    logic                  i_uses_rs1, i_uses_rs2;
    logic [DATA_W-1:0]     i_rs1_data, i_rs2_data, i_imm, i_pc;
    logic [FUNCT3_W-1:0]   i_funct3;
    logic [ALU_OP_W-1:0]   i_alu_op;
    logic                  i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_branch;

    logic [REG_ADDR_W-1:0] o_ID_EX_rs1, o_ID_EX_rs2, o_ID_EX_rd;
    logic [DATA_W-1:0]     o_ID_EX_rs1_data, o_ID_EX_rs2_data, o_ID_EX_imm, o_ID_EX_pc;
    logic [FUNCT3_W-1:0]   o_ID_EX_funct3;
    logic [ALU_OP_W-1:0]   o_ID_EX_alu_op;
    logic                  o_ID_EX_reg_write, o_ID_EX_mem_read, o_ID_EX_mem_write;
    logic                  o_ID_EX_mem_to_reg, o_ID_EX_alu_src, o_ID_EX_branch;
    logic                  o_valid;

    modport slave (
        input  i_IF_ID_rs1, i_IF_ID_rs2, i_IF_ID_rd, i_uses_rs1, i_uses_rs2,
               i_rs1_data, i_rs2_data, i_imm, i_pc, i_funct3, i_alu_op,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_branch,
        output o_ID_EX_rs1, o_ID_EX_rs2, o_ID_EX_rd,
               o_ID_EX_rs1_data, o_ID_EX_rs2_data, o_ID_EX_imm, o_ID_EX_pc,
               o_ID_EX_funct3, o_ID_EX_alu_op,
               o_ID_EX_reg_write, o_ID_EX_mem_read, o_ID_EX_mem_write,
               o_ID_EX_mem_to_reg, o_ID_EX_alu_src, o_ID_EX_branch, o_valid
    );

    modport master (
        output i_IF_ID_rs1, i_IF_ID_rs2, i_IF_ID_rd, i_uses_rs1, i_uses_rs2,
               i_rs1_data, i_rs2_data, i_imm, i_pc, i_funct3, i_alu_op,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_branch,
        input  o_ID_EX_rs1, o_ID_EX_rs2, o_ID_EX_rd,
               o_ID_EX_rs1_data, o_ID_EX_rs2_data, o_ID_EX_imm, o_ID_EX_pc,
               o_ID_EX_funct3, o_ID_EX_alu_op,
               o_ID_EX_reg_write, o_ID_EX_mem_read, o_ID_EX_mem_write,
               o_ID_EX_mem_to_reg, o_ID_EX_alu_src, o_ID_EX_branch, o_valid
    );

endinterface

// File: rtl/id_ex_stage_load_use_detector.sv
// Combinational load-use hazard: a valid load in EX whose non-x0 destination
// is a source register actually read by the instruction being decoded.
module load_use_detector
    import id_ex_stage_pkg::*;
(
    input  logic                  ex_mem_read_i,
    input  logic                  ex_valid_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    output logic                  hazard_c_o
);

    logic rs1_match_c;
    logic rs2_match_c;

    assign rs1_match_c = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
    assign rs2_match_c = id_uses_rs2_i && (ex_rd_i == id_rs2_i);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign hazard_c_o = ex_mem_read_i && ex_valid_i && (ex_rd_i != X0_ADDR)
                        && (rs1_match_c || rs2_match_c);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall request, flush/stall bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_flush,
    id_ex_stage_if.slave      bus,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_bubble_count
);

    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0]     rs1_data_q, rs2_data_q, imm_q, pc_q;
    logic [FUNCT3_W-1:0]   funct3_q;
    ctrl_t                 ctrl_in_c, ctrl_d, ctrl_q;
    logic                  valid_d, valid_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  hazard_c, load_bubble_c;

    assign ctrl_in_c = '{reg_write:  bus.i_reg_write,
                         mem_read:   bus.i_mem_read,
                         mem_write:  bus.i_mem_write,
                         mem_to_reg: bus.i_mem_to_reg,
                         alu_src:    bus.i_alu_src,
                         branch:     bus.i_branch,
                         alu_op:     bus.i_alu_op};

    load_use_detector u_load_use_detector (
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_valid_i    (valid_q),
        .ex_rd_i       (rd_q),
        .id_rs1_i      (bus.i_IF_ID_rs1),
        .id_rs2_i      (bus.i_IF_ID_rs2),
        .id_uses_rs1_i (bus.i_uses_rs1),
        .id_uses_rs2_i (bus.i_uses_rs2),
        .hazard_c_o    (hazard_c)
    );

    // A flush already discards the decoding instruction, so it masks the stall.
    assign o_stall       = hazard_c && !i_flush;
    assign load_bubble_c = i_flush || hazard_c;

    // Next slot contents: bubbles keep data fields but clear every control.
    always_comb begin
        ctrl_d  = ctrl_in_c;
        valid_d = 1'b1;
        cnt_d   = cnt_q;
        if (load_bubble_c) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            funct3_q   <= '0;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else if (i_enable) begin
            rs1_q      <= bus.i_IF_ID_rs1;
            rs2_q      <= bus.i_IF_ID_rs2;
            rd_q       <= bus.i_IF_ID_rd;
            rs1_data_q <= bus.i_rs1_data;
            rs2_data_q <= bus.i_rs2_data;
            imm_q      <= bus.i_imm;
            pc_q       <= bus.i_pc;
            funct3_q   <= bus.i_funct3;
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_ID_EX_rs1        = rs1_q;
    assign bus.o_ID_EX_rs2        = rs2_q;
    assign bus.o_ID_EX_rd         = rd_q;
    assign bus.o_ID_EX_rs1_data   = rs1_data_q;
    assign bus.o_ID_EX_rs2_data   = rs2_data_q;
    assign bus.o_ID_EX_imm        = imm_q;
    assign bus.o_ID_EX_pc         = pc_q;
    assign bus.o_ID_EX_funct3     = funct3_q;
    assign bus.o_ID_EX_alu_op     = ctrl_q.alu_op;
    assign bus.o_ID_EX_reg_write  = ctrl_q.reg_write;
    assign bus.o_ID_EX_mem_read   = ctrl_q.mem_read;
    assign bus.o_ID_EX_mem_write  = ctrl_q.mem_write;
    assign bus.o_ID_EX_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.o_ID_EX_alu_src    = ctrl_q.alu_src;
    assign bus.o_ID_EX_branch     = ctrl_q.branch;
    assign bus.o_valid            = valid_q;
    assign o_bubble_count         = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a slot-level model checked every cycle,
// plus literal expectations for the load-use, flush, hold and saturation cases.
module tb_id_ex_stage;

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] d1, d2, imm, pc;
        logic [2:0]  f3;
        logic [3:0]  aop;
        logic        rw, mr, mw, m2r, as, br;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b1;
    logic          flush = 1'b1;
    logic          stall;
    logic [CW-1:0] bcnt;

    instr_t cur    = '1;
    instr_t m_slot = '0;
    bit     m_bub  = 1'b1;
    int     m_cnt  = 0;
    int     checks = 0;
    int     errors = 0;

    id_ex_stage_if #(.DATA_W(DW)) bus ();

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_enable       (en),
        .i_flush        (flush),
        .bus            (bus),
        .o_stall        (stall),
        .o_bubble_count (bcnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.i_IF_ID_rs1  = cur.rs1;
        bus.i_IF_ID_rs2  = cur.rs2;
        bus.i_IF_ID_rd   = cur.rd;
        bus.i_uses_rs1   = cur.u1;
        bus.i_uses_rs2   = cur.u2;
        bus.i_rs1_data   = cur.d1;
        bus.i_rs2_data   = cur.d2;
        bus.i_imm        = cur.imm;
        bus.i_pc         = cur.pc;
        bus.i_funct3     = cur.f3;
        bus.i_alu_op     = cur.aop;
        bus.i_reg_write  = cur.rw;
        bus.i_mem_read   = cur.mr;
        bus.i_mem_write  = cur.mw;
        bus.i_mem_to_reg = cur.m2r;
        bus.i_alu_src    = cur.as;
        bus.i_branch     = cur.br;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The decoding instruction depends on a real load in EX with a nonzero destination.
    function automatic bit model_hazard();
        bit dep;
        dep = (cur.u1 && cur.rs1 == m_slot.rd) || (cur.u2 && cur.rs2 == m_slot.rd);
        return !m_bub && m_slot.mr && m_slot.rd != 5'd0 && dep;
    endfunction

    function automatic instr_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
        instr_t x = '0;
        x.rd = rd; x.rs1 = rs1; x.rs2 = 5'd9; x.u1 = 1'b1;
        x.d1 = 32'h1000 + pc; x.d2 = 32'hDEAD; x.imm = 32'h8; x.pc = pc; x.f3 = 3'd2;
        x.aop = 4'd2; x.rw = 1'b1; x.mr = 1'b1; x.m2r = 1'b1; x.as = 1'b1;
        return x;
    endfunction

    function automatic instr_t mk_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                      input bit u1, input bit u2, input logic [31:0] pc);
        instr_t x = '0;
        x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.d1 = 32'h11 + pc; x.d2 = 32'h22; x.imm = 32'h5; x.pc = pc; x.f3 = 3'd0;
        x.aop = 4'd3; x.rw = 1'b1; x.as = !u2; x.br = 1'b0;
        return x;
    endfunction

    // Slot-level model: each enabled edge captures the decoding instruction, marked as a bubble on flush or hazard.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slot = '0;
            m_bub  = 1'b1;
            m_cnt  = 0;
        end else if (en) begin
            bit b;
            b      = flush || model_hazard();
            m_slot = cur;
            m_bub  = b;
            if (b && m_cnt < CMAX) m_cnt++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit live;
        live = !m_bub;
        chk("valid",      64'(bus.o_valid),            64'(live));
        chk("rs1",        64'(bus.o_ID_EX_rs1),        64'(m_slot.rs1));
        chk("rs2",        64'(bus.o_ID_EX_rs2),        64'(m_slot.rs2));
        chk("rd",         64'(bus.o_ID_EX_rd),         64'(m_slot.rd));
        chk("rs1_data",   64'(bus.o_ID_EX_rs1_data),   64'(m_slot.d1));
        chk("rs2_data",   64'(bus.o_ID_EX_rs2_data),   64'(m_slot.d2));
        chk("imm",        64'(bus.o_ID_EX_imm),        64'(m_slot.imm));
        chk("pc",         64'(bus.o_ID_EX_pc),         64'(m_slot.pc));
        chk("funct3",     64'(bus.o_ID_EX_funct3),     64'(m_slot.f3));
        chk("alu_op",     64'(bus.o_ID_EX_alu_op),     live ? 64'(m_slot.aop) : 64'd0);
        chk("reg_write",  64'(bus.o_ID_EX_reg_write),  64'(live && m_slot.rw));
        chk("mem_read",   64'(bus.o_ID_EX_mem_read),   64'(live && m_slot.mr));
        chk("mem_write",  64'(bus.o_ID_EX_mem_write),  64'(live && m_slot.mw));
        chk("mem_to_reg", 64'(bus.o_ID_EX_mem_to_reg), 64'(live && m_slot.m2r));
        chk("alu_src",    64'(bus.o_ID_EX_alu_src),    64'(live && m_slot.as));
        chk("branch",     64'(bus.o_ID_EX_branch),     64'(live && m_slot.br));
        chk("stall",      64'(stall),                  64'(model_hazard() && !flush));
        chk("bubble_cnt", 64'(bcnt),                   64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input driven high.
        #1 rst_n = 1'b0;
        repeat (3) tick();
        #1;
        chk("L_rst_valid", 64'(bus.o_valid), 64'd0);
        chk("L_rst_stall", 64'(stall), 64'd0);
        chk("L_rst_cnt",   64'(bcnt), 64'd0);
        chk("L_rst_pc",    64'(bus.o_ID_EX_pc), 64'd0);
        chk("L_rst_mr",    64'(bus.o_ID_EX_mem_read), 64'd0);

        // Load-use: lw x5 then add x6,x5,x7.
        rst_n = 1'b1;
        flush = 1'b0;
        cur = mk_lw(5'd5, 5'd2, 32'h100);
        tick();
        chk("L_first_valid", 64'(bus.o_valid), 64'd1);
        cur = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 32'h104);
        #1 chk("L_lu_stall", 64'(stall), 64'd1);
        tick();
        chk("L_lu_bub_valid", 64'(bus.o_valid), 64'd0);
        chk("L_lu_bub_rw",    64'(bus.o_ID_EX_reg_write), 64'd0);
        chk("L_lu_bub_rd",    64'(bus.o_ID_EX_rd), 64'd6);
        chk("L_lu_cnt",       64'(bcnt), 64'd1);
        chk("L_lu_unstall",   64'(stall), 64'd0);
        tick();
        chk("L_lu_add_valid", 64'(bus.o_valid), 64'd1);
        chk("L_lu_add_pc",    64'(bus.o_ID_EX_pc), 64'h104);

        // No false stall: unused rs2 match, and load to x0.
        cur = mk_lw(5'd5, 5'd2, 32'h108);
        tick();
        cur = mk_alu(5'd6, 5'd0, 5'd5, 1'b1, 1'b0, 32'h10C);
        #1 chk("L_nouse_stall", 64'(stall), 64'd0);
        tick();
        cur = mk_lw(5'd0, 5'd3, 32'h110);
        tick();
        cur = mk_alu(5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 32'h114);
        #1 chk("L_x0_stall", 64'(stall), 64'd0);
        tick();
        chk("L_x0_valid", 64'(bus.o_valid), 64'd1);

        // Flush and hazard together.
        cur = mk_lw(5'd5, 5'd2, 32'h118);
        tick();
        cur = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 32'h11C);
        flush = 1'b1;
        #1 chk("L_fl_stall", 64'(stall), 64'd0);
        tick();
        chk("L_fl_valid", 64'(bus.o_valid), 64'd0);
        chk("L_fl_cnt",   64'(bcnt), 64'd2);
        flush = 1'b0;
        tick();
        chk("L_fl_after_valid", 64'(bus.o_valid), 64'd1);
        chk("L_fl_after_cnt",   64'(bcnt), 64'd2);

        // Hold with enable low while inputs and flush change.
        cur = mk_lw(5'd5, 5'd2, 32'h120);
        tick();
        en = 1'b0;
        flush = 1'b1;
        cur = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 32'h124);
        #1 chk("L_hold_stall_fl", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        cur = mk_alu(5'd8, 5'd1, 5'd5, 1'b1, 1'b1, 32'h128);
        #1 chk("L_hold_stall", 64'(stall), 64'd1);
        tick();
        flush = 1'b1;
        cur = mk_alu(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 32'h12C);
        tick();
        chk("L_hold_pc",  64'(bus.o_ID_EX_pc), 64'h120);
        chk("L_hold_mr",  64'(bus.o_ID_EX_mem_read), 64'd1);
        chk("L_hold_cnt", 64'(bcnt), 64'd2);
        en = 1'b1;

        // Saturation of the 4-bit bubble counter.
        repeat (17) tick();
        chk("L_sat_cnt", 64'(bcnt), 64'd15);

        // Reset asserted mid-stall drops stall and count before the next edge.
        flush = 1'b0;
        cur = mk_lw(5'd5, 5'd2, 32'h130);
        tick();
        cur = mk_alu(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 32'h134);
        #1 chk("L_pre_rst_stall", 64'(stall), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("L_mid_rst_stall", 64'(stall), 64'd0);
        chk("L_mid_rst_cnt",   64'(bcnt), 64'd0);
        chk("L_mid_rst_valid", 64'(bus.o_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("L_post_rst_valid", 64'(bus.o_valid), 64'd1);
        chk("L_post_rst_pc",    64'(bus.o_ID_EX_pc), 64'h134);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
